op_sequencer: RTL and testbench

// - Issuing end of the cpu op/done_out interface: holds a small program of `operation` words.
// - On start, drives each op onto the cpu in order and waits for done_out before advancing.
// - Replaces hand-driven op stimulus; sits between host/loader and cpu.

---
 rtl/op_sequencer_pkg.sv | 49 ++++
 rtl/op_sequencer_prog_mem.sv | 27 ++
 rtl/op_sequencer.sv | 157 +++++++++++++++
 tb/tb_op_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/op_sequencer_pkg.sv
// rtl/op_sequencer_pkg.sv - operation word types and op sequencer state encoding
package op_sequencer_pkg;

    localparam int OPSEQ_DEPTH   = 16;
    localparam int OPSEQ_TIMEOUT = 1024;

    typedef enum logic [2:0] {
        OP_NOP       = 3'd0,
        OP_CT_CT_ADD = 3'd1,
        OP_CT_PT_ADD = 3'd2,
        OP_CT_CT_MUL = 3'd3,
        OP_CT_PT_MUL = 3'd4
    } op_mode_e;

    // Two-lane ciphertext op: d0 = a0 (op) b0, d1 = a1 (op) b1 on register indices.
    typedef struct packed {
        op_mode_e   mode;
        logic [3:0] a0;
        logic [3:0] a1;
        logic [3:0] b0;
        logic [3:0] b1;
        logic [3:0] d0;
        logic [3:0] d1;
    } operation;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_DONE = 3'd2,
        SETTLE    = 3'd3,
        FINISH    = 3'd4
    } opseq_state_e;

    function automatic operation make_op(input op_mode_e m,
                                         input logic [3:0] a0, input logic [3:0] a1,
                                         input logic [3:0] b0, input logic [3:0] b1,
                                         input logic [3:0] d0, input logic [3:0] d1);
        operation o;
        o.mode = m;
        o.a0   = a0;
        o.a1   = a1;
        o.b0   = b0;
        o.b1   = b1;
        o.d0   = d0;
        o.d1   = d1;
        return o;
    endfunction

endpackage

// File: rtl/op_sequencer_prog_mem.sv
// rtl/op_sequencer_prog_mem.sv - op_prog_mem: program store, one write port, one async read port
module op_prog_mem
    import op_sequencer_pkg::*;
#(
    parameter  int DEPTH = OPSEQ_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  operation      wdata,
    input  logic [AW-1:0] raddr,
    output operation      rdata
);

    // Storage only; contents are undefined until the loader writes them.
    operation mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/op_sequencer.sv
// rtl/op_sequencer.sv - issues a stored op program to the cpu one op at a time
// Optional per-op done timeout is enabled by defining OPSEQ_TIMEOUT_EN.
module op_sequencer
    import op_sequencer_pkg::*;
#(
    parameter  int DEPTH   = OPSEQ_DEPTH,
    parameter  int TIMEOUT = OPSEQ_TIMEOUT,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  operation      prog_op,
    input  logic          start,
    input  logic [AW:0]   prog_len,
    output operation      op,
    input  logic          done_out,
    output logic          busy,
    output logic [AW:0]   pc,
    output logic          seq_done,
    output logic          err
);

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_L   = {{AW{1'b0}}, 1'b1};

    opseq_state_e state_q, state_d;
    logic [AW:0]  pc_q, pc_d;
    logic [AW:0]  len_q, len_d;
    operation     op_q, op_d;
    logic         err_q, err_d;
    logic         seq_done_q, seq_done_d;
    logic         mem_we;
    operation     rd_op;
    logic [AW:0]  pc_inc;
    logic [AW:0]  len_clamped;
    logic         tmo_hit;

    // Writes are only accepted while idle so a running program never changes under the cpu.
    assign mem_we      = prog_we && (state_q == IDLE);
    assign pc_inc      = pc_q + ONE_L;
    assign len_clamped = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;

    op_prog_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (prog_addr),
        .wdata (prog_op),
        .raddr (pc_q[AW-1:0]),
        .rdata (rd_op)
    );

`ifdef OPSEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt <= '0;
        end else if (state_q == WAIT_DONE) begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end else begin
            tmo_cnt <= '0;
        end
    end

    assign tmo_hit = (tmo_cnt == TW'(TIMEOUT - 1));
`else
    logic [31:0] timeout_unused;
    assign timeout_unused = 32'(TIMEOUT);
    assign tmo_hit        = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            len_q      <= '0;
            op_q       <= '0;
            err_q      <= 1'b0;
            seq_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            len_q      <= len_d;
            op_q       <= op_d;
            err_q      <= err_d;
            seq_done_q <= seq_done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        len_d      = len_q;
        op_d       = op_q;
        err_d      = err_q;
        seq_done_d = 1'b0;

        if ((state_q != IDLE) && (start || prog_we)) begin
            err_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                pc_d = '0;
                op_d = '0;
                if (start) begin
                    err_d   = 1'b0;
                    len_d   = len_clamped;
                    state_d = (prog_len == '0) ? FINISH : ISSUE;
                end
            end
            ISSUE: begin
                op_d    = rd_op;
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (done_out) begin
                    state_d = SETTLE;
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    op_d    = '0;
                    state_d = FINISH;
                end
            end
            SETTLE: begin
                // Hold here until done drops so a stuck-high done cannot retire the next op.
                if (!done_out) begin
                    pc_d    = pc_inc;
                    op_d    = '0;
                    state_d = (pc_inc == len_q) ? FINISH : ISSUE;
                end
            end
            FINISH: begin
                op_d       = '0;
                pc_d       = '0;
                seq_done_d = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                op_d    = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign op       = op_q;
    assign busy     = (state_q != IDLE);
    assign pc       = pc_q;
    assign seq_done = seq_done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_op_sequencer.sv
// tb/tb_op_sequencer.sv - directed self-checking bench for op_sequencer with a small cpu model
module tb_op_sequencer;
    import op_sequencer_pkg::*;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk       = 1'b0;
    logic          reset     = 1'b0;
    logic          prog_we   = 1'b0;
    logic [AW-1:0] prog_addr = '0;
    operation      prog_op   = '0;
    logic          start     = 1'b0;
    logic [AW:0]   prog_len  = '0;
    logic          done_out  = 1'b0;
    operation      op;
    logic          busy;
    logic [AW:0]   pc;
    logic          seq_done;
    logic          err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    op_sequencer #(
        .DEPTH   (DEPTH),
        .TIMEOUT (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_op   (prog_op),
        .start     (start),
        .prog_len  (prog_len),
        .op        (op),
        .done_out  (done_out),
        .busy      (busy),
        .pc        (pc),
        .seq_done  (seq_done),
        .err       (err)
    );

    // cpu model: raises done cpu_lat cycles after a new op appears, holds it cpu_hold cycles.
    int cpu_lat   = 3;
    int cpu_hold  = 1;
    bit cpu_en    = 1'b1;
    int cpu_phase = 0;
    int cpu_cnt   = 0;
    int rf [16];

    always @(negedge clk) begin
        if (!reset) begin
            cpu_phase = 0;
            done_out  = 1'b0;
        end else begin
            case (cpu_phase)
                0: if (op != '0) begin cpu_phase = 1; cpu_cnt = 0; end
                1: begin
                    cpu_cnt++;
                    if (op == '0) begin
                        cpu_phase = 0;
                    end else if (cpu_en && cpu_cnt == cpu_lat) begin
                        done_out  = 1'b1;
                        cpu_cnt   = 1;
                        cpu_phase = 2;
                        rf[op.d0] = rf[op.a0] + rf[op.b0];
                        rf[op.d1] = rf[op.a1] + rf[op.b1];
                    end
                end
                2: begin
                    if (cpu_cnt >= cpu_hold) begin done_out = 1'b0; cpu_phase = 3; end
                    else cpu_cnt++;
                end
                default: if (op == '0) cpu_phase = 0;
            endcase
        end
    end

    operation prev_op = '0;
    operation obs_ops[$];
    int       seq_cnt  = 0;
    int       busy_cnt = 0;

    always @(negedge clk) begin
        if (op != prev_op && op != '0) obs_ops.push_back(op);
        prev_op = op;
        if (seq_done) seq_cnt++;
        if (busy) busy_cnt++;
    end

    operation S0, S1, XOP, BAD;

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_obs();
        obs_ops.delete();
        seq_cnt  = 0;
        busy_cnt = 0;
    endtask

    task automatic write_slot(input int a, input operation o);
        prog_we   = 1'b1;
        prog_addr = a[AW-1:0];
        prog_op   = o;
        tick();
        prog_we   = 1'b0;
    endtask

    task automatic run(input logic [AW:0] len, input int max, output int n);
        int k;
        start    = 1'b1;
        prog_len = len;
        k = 0;
        do begin
            tick();
            start   = 1'b0;
            prog_we = 1'b0;
            k++;
        end while (!seq_done && k < max);
        n = seq_done ? k : -1;
    endtask

    task automatic test_reset();
        tick(); tick();
        n_checks++; if (op !== '0) begin n_fail++; $display("FAIL reset_op: got %h expected 0", op); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (pc !== '0) begin n_fail++; $display("FAIL reset_pc: got %0d expected 0", pc); end
        n_checks++; if (seq_done !== 1'b0) begin n_fail++; $display("FAIL reset_seq_done: got %b expected 0", seq_done); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
        reset = 1'b1;
        tick(); tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy: got %b expected 0", busy); end
    endtask

    task automatic test_program_run();
        int n;
        operation o0, o1;
        foreach (rf[i]) rf[i] = 0;
        rf[0] = 5; rf[1] = 1; rf[2] = 7; rf[3] = 2;
        write_slot(0, S0);
        write_slot(1, S1);
        clear_obs();
        run(5'd2, 200, n);
        o0 = (obs_ops.size() > 0) ? obs_ops[0] : '0;
        o1 = (obs_ops.size() > 1) ? obs_ops[1] : '0;
        n_checks++; if (n !== 14) begin n_fail++; $display("FAIL run_latency: got %0d expected 14", n); end
        n_checks++; if (obs_ops.size() !== 2) begin n_fail++; $display("FAIL run_op_count: got %0d expected 2", obs_ops.size()); end
        n_checks++; if (o0 !== S0) begin n_fail++; $display("FAIL run_op0: got %h expected %h", o0, S0); end
        n_checks++; if (o1 !== S1) begin n_fail++; $display("FAIL run_op1: got %h expected %h", o1, S1); end
        n_checks++; if (rf[6] !== 17) begin n_fail++; $display("FAIL run_rf6: got %0d expected 17", rf[6]); end
        n_checks++; if (rf[7] !== 4) begin n_fail++; $display("FAIL run_rf7: got %0d expected 4", rf[7]); end
        n_checks++; if (pc !== '0) begin n_fail++; $display("FAIL run_pc_idle: got %0d expected 0", pc); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL run_err: got %b expected 0", err); end
        tick(); tick();
        n_checks++; if (seq_cnt !== 1) begin n_fail++; $display("FAIL run_seq_done_count: got %0d expected 1", seq_cnt); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL run_busy_after: got %b expected 0", busy); end
    endtask

    task automatic test_empty_program();
        int n;
        clear_obs();
        run(5'd0, 20, n);
        n_checks++; if (n !== 2) begin n_fail++; $display("FAIL empty_latency: got %0d expected 2", n); end
        tick(); tick(); tick();
        n_checks++; if (busy_cnt !== 1) begin n_fail++; $display("FAIL empty_busy_cycles: got %0d expected 1", busy_cnt); end
        n_checks++; if (seq_cnt !== 1) begin n_fail++; $display("FAIL empty_seq_done_count: got %0d expected 1", seq_cnt); end
        n_checks++; if (obs_ops.size() !== 0) begin n_fail++; $display("FAIL empty_op_issued: got %0d expected 0", obs_ops.size()); end
    endtask

    task automatic test_done_held();
        int n;
        cpu_hold = 4;
        clear_obs();
        run(5'd2, 300, n);
        n_checks++; if (n !== 20) begin n_fail++; $display("FAIL held_latency: got %0d expected 20", n); end
        n_checks++; if (obs_ops.size() !== 2) begin n_fail++; $display("FAIL held_op_changes: got %0d expected 2", obs_ops.size()); end
        tick(); tick();
        n_checks++; if (seq_cnt !== 1) begin n_fail++; $display("FAIL held_seq_done_count: got %0d expected 1", seq_cnt); end
        cpu_hold = 1;
    endtask

    task automatic test_misuse();
        int n;
        operation o0;
        clear_obs();
        start    = 1'b1;
        prog_len = 5'd2;
        n = 0;
        do begin
            tick();
            start   = 1'b0;
            prog_we = 1'b0;
            n++;
            if (n == 4) begin
                n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL misuse_err_set: got %b expected 1", err); end
            end
            if (n == 3) begin
                start = 1'b1; prog_len = 5'd1;
                prog_we = 1'b1; prog_addr = '0; prog_op = BAD;
            end
        end while (!seq_done && n < 200);
        n_checks++; if (n !== 14) begin n_fail++; $display("FAIL misuse_run_latency: got %0d expected 14", n); end
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL misuse_err_sticky: got %b expected 1", err); end
        tick();
        clear_obs();
        start    = 1'b1;
        prog_len = 5'd1;
        tick();
        start = 1'b0;
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL misuse_err_cleared: got %b expected 0", err); end
        n = 1;
        while (!seq_done && n < 200) begin tick(); n++; end
        o0 = (obs_ops.size() > 0) ? obs_ops[0] : '0;
        n_checks++; if (n !== 8) begin n_fail++; $display("FAIL rerun_latency: got %0d expected 8", n); end
        n_checks++; if (o0 !== S0) begin n_fail++; $display("FAIL misuse_mem_unchanged: got %h expected %h", o0, S0); end
    endtask

    task automatic test_reset_mid_run();
        int n;
        operation o0;
        clear_obs();
        start    = 1'b1;
        prog_len = 5'd2;
        tick();
        start = 1'b0;
        tick(); tick();
        n_checks++; if (op !== S0) begin n_fail++; $display("FAIL midrst_op_before: got %h expected %h", op, S0); end
        #1 reset = 1'b0;
        #1;
        n_checks++; if (op !== '0) begin n_fail++; $display("FAIL midrst_op: got %h expected 0", op); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        tick();
        reset = 1'b1;
        tick(); tick(); tick();
        n_checks++; if (seq_cnt !== 0) begin n_fail++; $display("FAIL midrst_no_seq_done: got %0d expected 0", seq_cnt); end
        clear_obs();
        run(5'd2, 200, n);
        o0 = (obs_ops.size() > 0) ? obs_ops[0] : '0;
        n_checks++; if (n !== 14) begin n_fail++; $display("FAIL midrst_rerun_latency: got %0d expected 14", n); end
        n_checks++; if (o0 !== S0) begin n_fail++; $display("FAIL midrst_rerun_op0: got %h expected %h", o0, S0); end
    endtask

    task automatic test_clamp();
        int n;
        operation o0, o15;
        for (int i = 0; i < DEPTH; i++) begin
            write_slot(i, make_op(OP_CT_PT_MUL, 4'(i), 4'd0, 4'd0, 4'd0, 4'd8, 4'd9));
        end
        clear_obs();
        run(5'd31, 300, n);
        o0  = (obs_ops.size() > 0)  ? obs_ops[0]  : '0;
        o15 = (obs_ops.size() > 15) ? obs_ops[15] : '0;
        n_checks++; if (n !== 98) begin n_fail++; $display("FAIL clamp_latency: got %0d expected 98", n); end
        n_checks++; if (obs_ops.size() !== 16) begin n_fail++; $display("FAIL clamp_op_count: got %0d expected 16", obs_ops.size()); end
        n_checks++; if (o0 !== make_op(OP_CT_PT_MUL, 4'd0, 4'd0, 4'd0, 4'd0, 4'd8, 4'd9)) begin
            n_fail++; $display("FAIL clamp_op0: got %h", o0); end
        n_checks++; if (o15 !== make_op(OP_CT_PT_MUL, 4'd15, 4'd0, 4'd0, 4'd0, 4'd8, 4'd9)) begin
            n_fail++; $display("FAIL clamp_op15: got %h", o15); end
    endtask

    task automatic test_write_and_start();
        int n;
        operation o0;
        tick();
        clear_obs();
        prog_we   = 1'b1;
        prog_addr = '0;
        prog_op   = XOP;
        run(5'd1, 50, n);
        o0 = (obs_ops.size() > 0) ? obs_ops[0] : '0;
        n_checks++; if (n !== 8) begin n_fail++; $display("FAIL wrstart_latency: got %0d expected 8", n); end
        n_checks++; if (o0 !== XOP) begin n_fail++; $display("FAIL wrstart_new_word: got %h expected %h", o0, XOP); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL wrstart_err: got %b expected 0", err); end
    endtask

`ifdef OPSEQ_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        tick();
        cpu_en = 1'b0;
        clear_obs();
        run(5'd1, 100, n);
        n_checks++; if (n !== 11) begin n_fail++; $display("FAIL timeout_latency: got %0d expected 11", n); end
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL timeout_err: got %b expected 1", err); end
        n_checks++; if (pc !== '0) begin n_fail++; $display("FAIL timeout_pc: got %0d expected 0", pc); end
        cpu_en = 1'b1;
    endtask
`endif

    initial begin
        S0  = make_op(OP_CT_CT_ADD, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5);
        S1  = make_op(OP_CT_CT_ADD, 4'd4, 4'd5, 4'd0, 4'd1, 4'd6, 4'd7);
        XOP = make_op(OP_CT_CT_MUL, 4'd2, 4'd3, 4'd2, 4'd3, 4'd10, 4'd11);
        BAD = make_op(OP_CT_PT_ADD, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15);
        test_reset();
        test_program_run();
        test_empty_program();
        test_done_held();
        test_misuse();
        test_reset_mid_run();
        test_clamp();
        test_write_and_start();
`ifdef OPSEQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
